// File: rtl/control_sequencer.sv
// rtl/control_sequencer.sv - hardwired fetch/decode/execute sequencer for the Mini SRC datapath
`timescale 1ns/1ps

module control_sequencer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        run,
    input  logic [31:0] IR,
    input  logic        mem_rdy,
    output logic        mem_rd,
    output logic        MDR_read,
    output logic        e_MAR,
    output logic        e_MDR,
    output logic        e_IR,
    output logic        e_Y,
    output logic        e_Z,
    output logic        e_HI,
    output logic        e_LO,
    output logic        e_GP,
    output logic        incPC,
    output logic [3:0]  GP_addr,
    output logic [3:0]  ALU_op,
    output logic [4:0]  BusDataSelect,
    output logic        halted,
    output logic        illegal,
    output logic        bus_err,
    output logic [3:0]  state_o
);

    typedef enum logic [3:0] {
        S_IDLE = 4'd0,
        S_T0   = 4'd1,
        S_T1   = 4'd2,
        S_T2   = 4'd3,
        S_T3   = 4'd4,
        S_T4   = 4'd5,
        S_T5   = 4'd6,
        S_T6   = 4'd7,
        S_HALT = 4'd8
    } state_t;

    typedef enum logic [2:0] {
        K_ALU_R,
        K_ALU_I,
        K_MULDIV,
        K_UNARY,
        K_NOP,
        K_HALT,
        K_ILLEGAL
    } kind_t;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_SHR  = 4'd4;
    localparam logic [3:0] ALU_SHRA = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_MUL  = 4'd9;
    localparam logic [3:0] ALU_DIV  = 4'd10;
    localparam logic [3:0] ALU_NEG  = 4'd11;
    localparam logic [3:0] ALU_NOT  = 4'd12;

    localparam logic [4:0] SEL_ZHI = 5'd18;
    localparam logic [4:0] SEL_ZLO = 5'd19;
    localparam logic [4:0] SEL_PC  = 5'd20;
    localparam logic [4:0] SEL_MDR = 5'd21;
    localparam logic [4:0] SEL_C   = 5'd23;

    localparam bit         TIMEOUT_EN  = (MEM_TIMEOUT != 0);
    localparam logic [7:0] TIMEOUT_CNT = 8'(MEM_TIMEOUT);

    state_t      state;
    logic [7:0]  wait_cnt;
    kind_t       kind;
    logic [3:0]  op_alu;
    state_t      boundary_next;

    logic [4:0]  opcode;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [3:0]  rc;

    // Constant field bits go to the datapath's sign extender, not to this block.
    logic        unused_ir_bits;

    assign opcode         = IR[31:27];
    assign ra             = IR[26:23];
    assign rb             = IR[22:19];
    assign rc             = IR[18:15];
    assign unused_ir_bits = ^IR[14:0];
    assign state_o        = state;
    assign boundary_next  = run ? S_T0 : S_IDLE;

    // Classify the opcode and pick the ALU operation it needs.
    always_comb begin
        kind   = K_ILLEGAL;
        op_alu = ALU_ADD;
        case (opcode)
            5'b00011: begin kind = K_ALU_R;  op_alu = ALU_ADD;  end
            5'b00100: begin kind = K_ALU_R;  op_alu = ALU_SUB;  end
            5'b00101: begin kind = K_ALU_R;  op_alu = ALU_AND;  end
            5'b00110: begin kind = K_ALU_R;  op_alu = ALU_OR;   end
            5'b00111: begin kind = K_ALU_R;  op_alu = ALU_ROR;  end
            5'b01000: begin kind = K_ALU_R;  op_alu = ALU_ROL;  end
            5'b01001: begin kind = K_ALU_R;  op_alu = ALU_SHR;  end
            5'b01010: begin kind = K_ALU_R;  op_alu = ALU_SHRA; end
            5'b01011: begin kind = K_ALU_R;  op_alu = ALU_SHL;  end
            5'b01100: begin kind = K_ALU_I;  op_alu = ALU_ADD;  end
            5'b01101: begin kind = K_ALU_I;  op_alu = ALU_AND;  end
            5'b01110: begin kind = K_ALU_I;  op_alu = ALU_OR;   end
            5'b01111: begin kind = K_MULDIV; op_alu = ALU_DIV;  end
            5'b10000: begin kind = K_MULDIV; op_alu = ALU_MUL;  end
            5'b10001: begin kind = K_UNARY;  op_alu = ALU_NEG;  end
            5'b10010: begin kind = K_UNARY;  op_alu = ALU_NOT;  end
            5'b11010: kind = K_NOP;
            5'b11011: kind = K_HALT;
            default:  kind = K_ILLEGAL;
        endcase
    end

    // State sequencing, memory wait counter and sticky status flags.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= S_IDLE;
            wait_cnt <= 8'd0;
            halted   <= 1'b0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (run) state <= S_T0;
                S_T0: begin
                    wait_cnt <= 8'd0;
                    state    <= S_T1;
                end
                S_T1: begin
                    // A ready read in the timeout cycle still wins over the error.
                    if (mem_rdy) begin
                        state <= S_T2;
                    end else if (TIMEOUT_EN && wait_cnt == TIMEOUT_CNT) begin
                        bus_err <= 1'b1;
                        halted  <= 1'b1;
                        state   <= S_HALT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_T2: state <= S_T3;
                S_T3: begin
                    case (kind)
                        K_ALU_R, K_ALU_I, K_MULDIV: state <= S_T4;
                        K_UNARY:                    state <= S_T5;
                        K_NOP:                      state <= boundary_next;
                        K_HALT: begin
                            halted <= 1'b1;
                            state  <= S_HALT;
                        end
                        default: begin
                            illegal <= 1'b1;
                            halted  <= 1'b1;
                            state   <= S_HALT;
                        end
                    endcase
                end
                S_T4: state <= S_T5;
                S_T5: state <= (kind == K_MULDIV) ? S_T6 : boundary_next;
                S_T6: state <= boundary_next;
                S_HALT: state <= S_HALT;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath controls decoded from the current state and IR fields.
    always_comb begin
        mem_rd        = 1'b0;
        MDR_read      = 1'b0;
        e_MAR         = 1'b0;
        e_MDR         = 1'b0;
        e_IR          = 1'b0;
        e_Y           = 1'b0;
        e_Z           = 1'b0;
        e_HI          = 1'b0;
        e_LO          = 1'b0;
        e_GP          = 1'b0;
        incPC         = 1'b0;
        GP_addr       = 4'd0;
        ALU_op        = 4'd0;
        BusDataSelect = 5'd0;
        case (state)
            S_T0: begin
                BusDataSelect = SEL_PC;
                e_MAR         = 1'b1;
                incPC         = 1'b1;
            end
            S_T1: begin
                mem_rd   = 1'b1;
                MDR_read = 1'b1;
                e_MDR    = mem_rdy;
            end
            S_T2: begin
                BusDataSelect = SEL_MDR;
                e_IR          = 1'b1;
            end
            S_T3: begin
                case (kind)
                    K_ALU_R, K_ALU_I: begin
                        BusDataSelect = {1'b0, rb};
                        GP_addr       = rb;
                        e_Y           = 1'b1;
                    end
                    K_MULDIV: begin
                        BusDataSelect = {1'b0, ra};
                        GP_addr       = ra;
                        e_Y           = 1'b1;
                    end
                    K_UNARY: begin
                        BusDataSelect = {1'b0, rb};
                        GP_addr       = rb;
                        ALU_op        = op_alu;
                        e_Z           = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                ALU_op = op_alu;
                e_Z    = 1'b1;
                case (kind)
                    K_ALU_R: begin
                        BusDataSelect = {1'b0, rc};
                        GP_addr       = rc;
                    end
                    K_MULDIV: begin
                        BusDataSelect = {1'b0, rb};
                        GP_addr       = rb;
                    end
                    default: BusDataSelect = SEL_C;
                endcase
            end
            S_T5: begin
                BusDataSelect = SEL_ZLO;
                if (kind == K_MULDIV) begin
                    e_LO = 1'b1;
                end else begin
                    GP_addr = ra;
                    e_GP    = 1'b1;
                end
            end
            S_T6: begin
                BusDataSelect = SEL_ZHI;
                e_HI          = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// tb/tb_control_sequencer.sv - randomized self-checking bench for control_sequencer
`timescale 1ns/1ps

module tb_control_sequencer;

    logic        clock = 1'b0;
    logic        clear;
    logic        run;
    logic [31:0] IR;
    logic        mem_rdy;
    logic        mem_rd, MDR_read, e_MAR, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_GP, incPC;
    logic [3:0]  GP_addr, ALU_op, state_o;
    logic [4:0]  BusDataSelect;
    logic        halted, illegal, bus_err;

    control_sequencer #(.MEM_TIMEOUT(15)) dut (
        .clock(clock), .clear(clear), .run(run), .IR(IR), .mem_rdy(mem_rdy),
        .mem_rd(mem_rd), .MDR_read(MDR_read), .e_MAR(e_MAR), .e_MDR(e_MDR),
        .e_IR(e_IR), .e_Y(e_Y), .e_Z(e_Z), .e_HI(e_HI), .e_LO(e_LO), .e_GP(e_GP),
        .incPC(incPC), .GP_addr(GP_addr), .ALU_op(ALU_op),
        .BusDataSelect(BusDataSelect), .halted(halted), .illegal(illegal),
        .bus_err(bus_err), .state_o(state_o)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_rd, mdr_read, e_mar, e_mdr, e_ir, e_y, e_z, e_hi, e_lo, e_gp, inc_pc;
        logic [3:0] gp;
        logic [3:0] alu;
        logic [4:0] bsel;
    } snap_t;

    int    checks = 0;
    int    errors = 0;
    logic  exp_halted, exp_illegal, exp_bus_err;
    snap_t exp_q[$];

    function automatic snap_t get_snap();
        snap_t s;
        s.st = state_o; s.mem_rd = mem_rd; s.mdr_read = MDR_read; s.e_mar = e_MAR;
        s.e_mdr = e_MDR; s.e_ir = e_IR; s.e_y = e_Y; s.e_z = e_Z; s.e_hi = e_HI;
        s.e_lo = e_LO; s.e_gp = e_GP; s.inc_pc = incPC; s.gp = GP_addr;
        s.alu = ALU_op; s.bsel = BusDataSelect;
        return s;
    endfunction

    function automatic snap_t blank(input logic [3:0] st);
        snap_t s = '0;
        s.st = st;
        return s;
    endfunction

    // 0 R-type, 1 immediate, 2 mul/div, 3 unary, 4 nop, 5 halt, 6 illegal
    function automatic int kind_of(input logic [4:0] op);
        int v = int'(op);
        if (v >= 3 && v <= 11) return 0;
        if (v >= 12 && v <= 14) return 1;
        if (v == 15 || v == 16) return 2;
        if (v == 17 || v == 18) return 3;
        if (v == 26) return 4;
        if (v == 27) return 5;
        return 6;
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        logic [3:0] rtab [0:8] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd7, 4'd8, 4'd4, 4'd5, 4'd6};
        logic [3:0] itab [0:2] = '{4'd0, 4'd2, 4'd3};
        logic [3:0] mtab [0:3] = '{4'd10, 4'd9, 4'd11, 4'd12};
        int v = int'(op);
        if (v >= 3 && v <= 11) return rtab[v - 3];
        if (v >= 12 && v <= 14) return itab[v - 12];
        if (v >= 15 && v <= 18) return mtab[v - 15];
        return 4'd0;
    endfunction

    // Expected per-cycle micro-operations of one instruction, T0 through its last step.
    function automatic void build(input logic [31:0] ir, input int waits);
        snap_t      s;
        logic [3:0] ra = ir[26:23];
        logic [3:0] rb = ir[22:19];
        logic [3:0] rc = ir[18:15];
        int         k  = kind_of(ir[31:27]);
        logic [3:0] a  = alu_of(ir[31:27]);
        s = blank(4'd1); s.bsel = 5'd20; s.e_mar = 1'b1; s.inc_pc = 1'b1; exp_q.push_back(s);
        for (int w = 0; w < waits; w++) begin
            s = blank(4'd2); s.mem_rd = 1'b1; s.mdr_read = 1'b1; exp_q.push_back(s);
        end
        s = blank(4'd2); s.mem_rd = 1'b1; s.mdr_read = 1'b1; s.e_mdr = 1'b1; exp_q.push_back(s);
        s = blank(4'd3); s.bsel = 5'd21; s.e_ir = 1'b1; exp_q.push_back(s);
        s = blank(4'd4);
        if (k == 0 || k == 1) begin s.bsel = {1'b0, rb}; s.gp = rb; s.e_y = 1'b1; end
        if (k == 2) begin s.bsel = {1'b0, ra}; s.gp = ra; s.e_y = 1'b1; end
        if (k == 3) begin s.bsel = {1'b0, rb}; s.gp = rb; s.alu = a; s.e_z = 1'b1; end
        exp_q.push_back(s);
        if (k <= 2) begin
            s = blank(4'd5); s.alu = a; s.e_z = 1'b1;
            if (k == 0) begin s.bsel = {1'b0, rc}; s.gp = rc; end
            if (k == 1) s.bsel = 5'd23;
            if (k == 2) begin s.bsel = {1'b0, rb}; s.gp = rb; end
            exp_q.push_back(s);
        end
        if (k <= 3) begin
            s = blank(4'd6); s.bsel = 5'd19;
            if (k == 2) s.e_lo = 1'b1;
            else begin s.gp = ra; s.e_gp = 1'b1; end
            exp_q.push_back(s);
        end
        if (k == 2) begin
            s = blank(4'd7); s.bsel = 5'd18; s.e_hi = 1'b1; exp_q.push_back(s);
        end
    endfunction

    // Runs one instruction starting in T0 at posedge+1; stop_at >= 0 leaves it mid-way at that step.
    task automatic run_instr(input logic [31:0] ir, input int waits, input logic last_run, input int stop_at);
        snap_t act, exp;
        int    k = kind_of(ir[31:27]);
        IR = ir;
        exp_q.delete();
        build(ir, waits);
        for (int i = 0; i < exp_q.size(); i++) begin
            exp     = exp_q[i];
            mem_rdy = (exp.st == 4'd2) ? exp.e_mdr : 1'($urandom);
            run     = (i == exp_q.size() - 1) ? last_run : 1'($urandom);
            #4;
            act = get_snap();
            checks++;
            if (act !== exp) begin
                errors++;
                $display("FAIL step%0d ir=%h: outputs %h, required %h", i, ir, act, exp);
            end
            checks++;
            if ({halted, illegal, bus_err} !== {exp_halted, exp_illegal, exp_bus_err}) begin
                errors++;
                $display("FAIL flags step%0d ir=%h: %b, required %b", i, ir,
                         {halted, illegal, bus_err}, {exp_halted, exp_illegal, exp_bus_err});
            end
            if (i == stop_at) return;
            @(posedge clock); #1;
        end
        if (k >= 5) begin
            exp_halted = 1'b1;
            if (k == 6) exp_illegal = 1'b1;
            for (int c = 0; c < 3; c++) begin
                run = 1'($urandom); mem_rdy = 1'($urandom); IR = $urandom;
                #4;
                checks++;
                if (get_snap() !== blank(4'd8) || {halted, illegal, bus_err} !== {exp_halted, exp_illegal, exp_bus_err}) begin
                    errors++;
                    $display("FAIL halt_hold ir=%h: outputs %h flags %b, required %h flags %b", ir,
                             get_snap(), {halted, illegal, bus_err}, blank(4'd8), {exp_halted, exp_illegal, exp_bus_err});
                end
                @(posedge clock); #1;
            end
        end else if (!last_run) begin
            run = 1'b0; mem_rdy = 1'($urandom);
            #4;
            checks++;
            if (get_snap() !== blank(4'd0)) begin
                errors++;
                $display("FAIL boundary_idle ir=%h: outputs %h, required %h", ir, get_snap(), blank(4'd0));
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic go_from_idle();
        run = 1'b1; mem_rdy = 1'($urandom);
        #4;
        checks++;
        if (get_snap() !== blank(4'd0) || {halted, illegal, bus_err} !== {exp_halted, exp_illegal, exp_bus_err}) begin
            errors++;
            $display("FAIL idle_start: outputs %h flags %b, required %h flags %b",
                     get_snap(), {halted, illegal, bus_err}, blank(4'd0), {exp_halted, exp_illegal, exp_bus_err});
        end
        @(posedge clock); #1;
    endtask

    task automatic apply_clear();
        clear = 1'b1; run = 1'b0;
        @(posedge clock); #1;
        clear = 1'b0;
        exp_halted = 1'b0; exp_illegal = 1'b0; exp_bus_err = 1'b0;
    endtask

    task automatic test_reset();
        clear = 1'b1;
        @(posedge clock); #1;
        for (int c = 0; c < 4; c++) begin
            run = 1'($urandom); mem_rdy = 1'($urandom); IR = $urandom;
            #4;
            checks++;
            if (get_snap() !== blank(4'd0) || {halted, illegal, bus_err} !== 3'b000) begin
                errors++;
                $display("FAIL reset: outputs %h flags %b, required %h flags 000",
                         get_snap(), {halted, illegal, bus_err}, blank(4'd0));
            end
            @(posedge clock); #1;
        end
        clear = 1'b0; run = 1'b0;
        for (int c = 0; c < 3; c++) begin
            mem_rdy = 1'($urandom);
            #4;
            checks++;
            if (get_snap() !== blank(4'd0)) begin
                errors++;
                $display("FAIL idle_hold: outputs %h, required %h", get_snap(), blank(4'd0));
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_add_mul();
        go_from_idle();
        run_instr(32'h18918000, 0, 1'b1, -1);
        run_instr(32'h82280000, 0, 1'b1, -1);
        run_instr({5'b11010, 27'($urandom)}, 0, 1'b0, -1);
    endtask

    task automatic test_wait();
        go_from_idle();
        run_instr({5'b00011, 27'($urandom)}, 3, 1'b1, -1);
        run_instr({5'b01100, 27'($urandom)}, 15, 1'b0, -1);
    endtask

    task automatic test_latency();
        logic [4:0] ops  [0:4] = '{5'b00011, 5'b01101, 5'b10000, 5'b10001, 5'b11010};
        int         lats [0:4] = '{6, 6, 7, 5, 4};
        int         n;
        go_from_idle();
        mem_rdy = 1'b1;
        for (int j = 0; j < 5; j++) begin
            IR = {ops[j], 27'($urandom)};
            n = 0;
            for (int c = 0; c < 50; c++) begin
                @(posedge clock); #1;
                n++;
                #4;
                if (state_o == 4'd1) break;
            end
            checks++;
            if (n !== lats[j]) begin
                errors++;
                $display("FAIL latency op=%b: %0d cycles, required %0d", ops[j], n, lats[j]);
            end
        end
        run = 1'b0; IR = {5'b11010, 27'd0};
        repeat (4) @(posedge clock);
        #5;
        checks++;
        if (state_o !== 4'd0) begin
            errors++;
            $display("FAIL latency_idle: state %0d, required 0", state_o);
        end
        @(posedge clock); #1;
    endtask

    task automatic test_back_to_back();
        logic [4:0] op;
        int         waits;
        go_from_idle();
        for (int i = 0; i < 24; i++) begin
            op    = 5'($urandom_range(3, 19));
            if (op == 5'd19) op = 5'b11010;
            waits = ($urandom_range(0, 7) == 0) ? 15 : $urandom_range(0, 3);
            run_instr({op, 27'($urandom)}, waits, (i == 23) ? 1'b0 : 1'b1, -1);
        end
    endtask

    task automatic test_run_drop();
        go_from_idle();
        run_instr({5'b00100, 27'($urandom)}, 1, 1'b0, -1);
        for (int c = 0; c < 2; c++) begin
            mem_rdy = 1'($urandom);
            #4;
            checks++;
            if (state_o !== 4'd0) begin
                errors++;
                $display("FAIL run_drop_idle: state %0d, required 0", state_o);
            end
            @(posedge clock); #1;
        end
    endtask

    task automatic test_clear_mid();
        go_from_idle();
        run_instr(32'h18918000, 0, 1'b1, 4);
        #1 clear = 1'b1;
        #1;
        checks++;
        if (get_snap() !== blank(4'd0)) begin
            errors++;
            $display("FAIL clear_async: outputs %h, required %h", get_snap(), blank(4'd0));
        end
        @(posedge clock); #1;
        clear = 1'b0; run = 1'b0;
        #4;
        checks++;
        if (get_snap() !== blank(4'd0) || e_GP !== 1'b0) begin
            errors++;
            $display("FAIL clear_after: outputs %h, required %h", get_snap(), blank(4'd0));
        end
        @(posedge clock); #1;
    endtask

    task automatic test_halt();
        go_from_idle();
        run_instr({5'b11011, 27'($urandom)}, 0, 1'b1, -1);
        apply_clear();
    endtask

    task automatic test_illegal();
        logic [4:0] bad [0:3] = '{5'b11111, 5'b00000, 5'b10011, 5'b11100};
        for (int j = 0; j < 4; j++) begin
            go_from_idle();
            run_instr({bad[j], 27'($urandom)}, $urandom_range(0, 2), 1'b1, -1);
            apply_clear();
        end
    endtask

    task automatic test_timeout();
        int n = 0;
        go_from_idle();
        mem_rdy = 1'b0;
        @(posedge clock); #1;
        for (int c = 0; c < 100; c++) begin
            mem_rdy = 1'b0;
            #4;
            if (state_o !== 4'd2) break;
            n++;
            checks++;
            if (e_MDR !== 1'b0 || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: e_MDR=%b bus_err=%b, required 0 0", n, e_MDR, bus_err);
            end
            @(posedge clock); #1;
        end
        checks++;
        if (n !== 16 || state_o !== 4'd8 || {halted, illegal, bus_err} !== 3'b101) begin
            errors++;
            $display("FAIL timeout: t1_cycles=%0d state=%0d flags=%b, required 16 8 101",
                     n, state_o, {halted, illegal, bus_err});
        end
        @(posedge clock); #1;
        apply_clear();
    endtask

    initial begin
        clear = 1'b1; run = 1'b0; mem_rdy = 1'b0; IR = 32'd0;
        exp_halted = 1'b0; exp_illegal = 1'b0; exp_bus_err = 1'b0;
        test_reset();
        test_add_mul();
        test_wait();
        test_latency();
        test_back_to_back();
        test_run_drop();
        test_clear_mid();
        test_halt();
        test_illegal();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit for the Mini SRC datapath. It fetches each instruction through MAR/MDR with a memory ready handshake and decodes IR. It then drives the datapath's per-cycle enables, bus-source select, register address and ALU opcode to execute ALU, immediate, multiply/divide, negate/not, nop and halt instructions. It replaces bench-driven T-state sequencing and sits directly beside the datapath, sharing its clock and clear.

## Interface
- MEM_TIMEOUT, 15: maximum cycles waiting in T1 for mem_rdy before a bus error; 0 disables the timeout.
- clock  in  1  system clock; all state changes on the rising edge.
- clear  in  1  reset, asynchronous and active-high.
- run  in  1  start/continue execution; sampled in IDLE and at instruction boundaries.
- IR  in  32  datapath instruction register.
- mem_rdy  in  1  memory read data valid on Mdatain this cycle.
- mem_rd  out  1  memory read request.
- MDR_read  out  1  MDR input mux selects Mdatain.
- e_MAR, e_MDR, e_IR, e_Y, e_Z, e_HI, e_LO, e_GP  out  1 each  register load enables.
- incPC  out  1  PC increment.
- GP_addr  out  4  register-file read/write address.
- ALU_op  out  4  ALU operation code.
- BusDataSelect  out  5  bus source select.
- halted  out  1  halt instruction executed.
- illegal  out  1  undefined opcode encountered.
- bus_err  out  1  memory timeout occurred.
- state_o  out  4  current state code, for debug.

## Operation
- IR field positions: opcode IR[31:27], Ra IR[26:23], Rb IR[22:19], Rc IR[18:15].
- BusDataSelect codes:
  - 0–15: R0–R15.
  - 16: HI. 17: LO. 18: Z high. 19: Z low.
  - 20: PC. 21: MDR. 23: sign-extended C.
- ALU_op codes: ADD 0, SUB 1, AND 2, OR 3, SHR 4, SHRA 5, SHL 6, ROR 7, ROL 8, MUL 9, DIV 10, NEG 11, NOT 12.
- Opcodes:
  - R-type (Ra ← Rb op Rc): add 00011, sub 00100, and 00101, or 00110, ror 00111, rol 01000, shr 01001, shra 01010, shl 01011.
  - Immediate (Ra ← Rb op C): addi 01100, andi 01101, ori 01110.
  - Multiply/divide (HI:LO ← Ra op Rb): div 01111, mul 10000.
  - Unary (Ra ← op Rb): neg 10001, not 10010.
  - nop 11010, halt 11011.
  - Any other opcode is illegal.
- States (state_o code):
  - IDLE (0): all outputs 0. Moves to T0 when run=1.
  - T0 (1): BusDataSelect=20, e_MAR=1, incPC=1.
  - T1 (2): mem_rd=1 and MDR_read=1.
    - e_MDR=1 only in the cycle where mem_rdy=1; then go to T2.
    - Otherwise stay in T1 and increment wait counter.
  - T2 (3): BusDataSelect=21, e_IR=1.
  - T3 (4): depends on opcode.
    - R-type/immediate: BusDataSelect=Rb, e_Y=1.
    - mul/div: BusDataSelect=Ra, e_Y=1.
    - neg/not: BusDataSelect=Rb, ALU_op set, e_Z=1, next state T5.
    - nop: next state is the boundary.
    - halt: next state HALT.
    - illegal: set illegal=1, next state HALT.
  - T4 (5): ALU_op set, e_Z=1.
    - BusDataSelect=Rc for R-type, 23 for immediate, Rb for mul/div.
  - T5 (6): writeback.
    - ALU ops: BusDataSelect=19, GP_addr=Ra, e_GP=1.
    - mul/div: BusDataSelect=19, e_LO=1, next state T6.
  - T6 (7): BusDataSelect=18, e_HI=1.
  - HALT (8): halted=1, all enables 0. Held until clear.
- Boundary rule: after the last state of an instruction, go to T0 if run=1, otherwise IDLE.
- GP_addr is 0 in every state except T3, T4 and T5, where it equals the field driven onto or written from the bus.
- Enables, selects and ALU_op are combinational from the state register and IR. halted, illegal and bus_err are registered sticky flags, cleared only by clear.
- Wait counter:
  - 8 bits, reset on entry to T1.
  - When MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_rdy=0: set bus_err and go to HALT.
  - If mem_rdy=1 in that same cycle, the read is accepted with no error.

## Timing
- Reset: clear=1 forces IDLE immediately, independent of clock.
  - All outputs are 0, including flags and state_o.
  - clear mid-instruction abandons that instruction with no further enables.
- Latency from T0 with mem_rdy already high:
  - R-type and immediate: 6 cycles.
  - mul/div: 7 cycles.
  - neg/not: 5 cycles.
  - nop: 4 cycles.
  - Each cycle of mem_rdy low adds one cycle.
- Dropping run mid-instruction does not abort it; run is checked only at the boundary.
- IR is stable from the edge after T2; T3 decodes the new IR.

## Test plan
- clear=1 with random inputs → all outputs 0, state_o=0. After release with run=0, remain in IDLE.
- IR=0x18918000 (add R1,R2,R3), mem_rdy=1 → exact sequence:
  - T3: BusDataSelect=2, e_Y.
  - T4: BusDataSelect=3, ALU_op=0, e_Z.
  - T5: BusDataSelect=19, GP_addr=1, e_GP.
  - Next cycle is T0.
- mem_rdy held low for 3 cycles → T1 lasts 4 cycles, e_MDR high only in the 4th; no bus_err.
- mem_rdy never asserted, MEM_TIMEOUT=15 → bus_err=1 and state_o=8 after 16 cycles in T1.
- IR=0x82280000 (mul R4,R5):
  - T3: BusDataSelect=4. T4: BusDataSelect=5, ALU_op=9.
  - T5: BusDataSelect=19, e_LO. T6: BusDataSelect=18, e_HI.
- Two halt-path cases:
  - IR=0xD8000000 → halted=1 one cycle after T3 and held.
  - Opcode 11111 → illegal=1, halted=1.
- Mid-instruction controls:
  - clear pulsed during T4 of an add → immediate IDLE with no e_GP.
  - run dropped during T4 → add completes, then IDLE.
